// File: rtl/neuron_mac_q88_if.sv
// Beat-in / result-out bundle for the Q8.8 MAC neuron.
// The result side feeds the sigmoid stage directly and has no back-pressure.
interface neuron_mac_q88_if;
    logic        valid_in;
    logic [15:0] x_in;
    logic [15:0] w_in;
    logic [15:0] bias_in;
    logic        in_ready;
    logic        valid_out;
    logic [15:0] y_out;
    logic        sat_out;

    modport master (
        output valid_in, x_in, w_in, bias_in,
        input  in_ready, valid_out, y_out, sat_out
    );

    modport slave (
        input  valid_in, x_in, w_in, bias_in,
        output in_ready, valid_out, y_out, sat_out
    );
endinterface

// File: rtl/neuron_mac_q88.sv
// Serial Q8.8 multiply-accumulate neuron: z = sum(x_i*w_i) + b over N_INPUTS beats.
// The sum is kept exact (Q24.16) and rounded/saturated to Q8.8 once per vector.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | waiting for the first beat; it loads p, bias and clears acc
//   S_ACC   | folding the previous product into acc, taking further beats
//   S_DRAIN | folding the final product into acc; beats refused
//   S_OUT   | round, saturate, register y_out/sat_out and pulse valid_out
module neuron_mac_q88 #(
    parameter int N_INPUTS = 16,
    parameter int ACC_W    = 40
) (
    input  logic             clk,
    input  logic             rst,
    neuron_mac_q88_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN, S_OUT} state_t;

    localparam int CNT_W = $clog2(N_INPUTS + 1);
    localparam logic [CNT_W-1:0]    N_LAST = CNT_W'(N_INPUTS);
    localparam logic signed [ACC_W:0] Q_MAX = (ACC_W+1)'(32767);
    localparam logic signed [ACC_W:0] Q_MIN = (ACC_W+1)'(-32768);
    localparam logic signed [ACC_W:0] RND   = (ACC_W+1)'(128);

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [31:0]        p_q, p_d;
    logic                      p_valid_q, p_valid_d;
    logic [15:0]               bias_q, bias_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      in_ready_q, in_ready_d;
    logic                      valid_out_q, valid_out_d;
    logic [15:0]               y_q, y_d;
    logic                      sat_q, sat_d;

    logic                      accept;
    logic signed [31:0]        x_ext, w_ext, prod;
    logic signed [ACC_W-1:0]   p_ext;
    logic signed [ACC_W:0]     s, q;

    assign accept = bus.valid_in && in_ready_q;
    assign x_ext  = {{16{bus.x_in[15]}}, bus.x_in};
    assign w_ext  = {{16{bus.w_in[15]}}, bus.w_in};
    assign prod   = x_ext * w_ext;
    assign p_ext  = {{(ACC_W-32){p_q[31]}}, p_q};

    // Bias moves from Q8.8 to the Q24.16 accumulator scale; +128 rounds half up.
    assign s = {acc_q[ACC_W-1], acc_q}
             + {{(ACC_W-23){bias_q[15]}}, bias_q, 8'd0}
             + RND;
    assign q = s >>> 8;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        p_d         = p_q;
        p_valid_d   = 1'b0;
        bias_d      = bias_q;
        cnt_d       = cnt_q;
        valid_out_d = 1'b0;
        y_d         = y_q;
        sat_d       = sat_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    p_d       = prod;
                    p_valid_d = 1'b1;
                    acc_d     = '0;
                    bias_d    = bus.bias_in;
                    cnt_d     = CNT_W'(1);
                    state_d   = (N_INPUTS == 1) ? S_DRAIN : S_ACC;
                end
            end
            S_ACC: begin
                if (p_valid_q)
                    acc_d = acc_q + p_ext;
                if (accept) begin
                    p_d       = prod;
                    p_valid_d = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (cnt_q + CNT_W'(1) == N_LAST)
                        state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                acc_d   = acc_q + p_ext;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (q > Q_MAX) begin
                    y_d   = 16'h7fff;
                    sat_d = 1'b1;
                end else if (q < Q_MIN) begin
                    y_d   = 16'h8000;
                    sat_d = 1'b1;
                end else begin
                    y_d   = q[15:0];
                    sat_d = 1'b0;
                end
                valid_out_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_IDLE) || (state_d == S_ACC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            p_q         <= '0;
            p_valid_q   <= 1'b0;
            bias_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            valid_out_q <= 1'b0;
            y_q         <= '0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            p_q         <= p_d;
            p_valid_q   <= p_valid_d;
            bias_q      <= bias_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            valid_out_q <= valid_out_d;
            y_q         <= y_d;
            sat_q       <= sat_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.valid_out = valid_out_q;
    assign bus.y_out     = y_q;
    assign bus.sat_out   = sat_q;

endmodule

// File: tb/tb_neuron_mac_q88.sv
// Directed bench for neuron_mac_q88: N=4 instance for most cases, N=1 instance for
// the single-beat rounding case. Inputs change and outputs are sampled 1ns after posedge.
module tb_neuron_mac_q88;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    neuron_mac_q88_if bus ();
    neuron_mac_q88_if bus1 ();

    neuron_mac_q88 #(.N_INPUTS(4), .ACC_W(40)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    neuron_mac_q88 #(.N_INPUTS(1), .ACC_W(40)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [15:0] x, input logic [15:0] w, input logic [15:0] b);
        bus.valid_in = 1'b1;
        bus.x_in     = x;
        bus.w_in     = w;
        bus.bias_in  = b;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            bus.valid_in = 1'b0;
            bus.x_in     = 16'h5a5a;
            bus.w_in     = 16'h3c3c;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic vec4(input logic [15:0] x, input logic [15:0] w, input logic [15:0] b);
        repeat (4) beat(x, w, b);
    endtask

    // Called 1ns after the edge that took the last beat; result must land 2 edges later.
    task automatic expect_result(input string tag, input int y, input int sat,
                                 input bit hold_valid);
        chk({tag, ".rdy_k"}, {31'd0, bus.in_ready}, 0);
        chk({tag, ".vo_k"},  {31'd0, bus.valid_out}, 0);
        if (hold_valid) begin
            bus.valid_in = 1'b1;
            bus.x_in     = 16'h7fff;
            bus.w_in     = 16'h7fff;
            bus.bias_in  = 16'h7fff;
        end
        @(posedge clk);
        #1;
        chk({tag, ".rdy_k1"}, {31'd0, bus.in_ready}, 0);
        chk({tag, ".vo_k1"},  {31'd0, bus.valid_out}, 0);
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        chk({tag, ".vo"},  {31'd0, bus.valid_out}, 1);
        chk({tag, ".y"},   $signed(bus.y_out), y);
        chk({tag, ".sat"}, {31'd0, bus.sat_out}, sat);
        chk({tag, ".rdy"}, {31'd0, bus.in_ready}, 1);
    endtask

    initial begin
        bus.valid_in  = 1'b0;
        bus.x_in      = '0;
        bus.w_in      = '0;
        bus.bias_in   = '0;
        bus1.valid_in = 1'b0;
        bus1.x_in     = '0;
        bus1.w_in     = '0;
        bus1.bias_in  = '0;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset.vo",  {31'd0, bus.valid_out}, 0);
        chk("reset.y",   $signed(bus.y_out), 0);
        chk("reset.sat", {31'd0, bus.sat_out}, 0);
        chk("reset.rdy", {31'd0, bus.in_ready}, 1);

        // 4 x (1.0 * 0.5) = 2.0
        vec4(16'd256, 16'd128, 16'd0);
        expect_result("basic", 512, 0, 1'b0);
        idle(1);
        chk("basic.pulse_end", {31'd0, bus.valid_out}, 0);
        chk("basic.y_hold", $signed(bus.y_out), 512);

        // Bias taken from the first beat only
        beat(16'd0, 16'd0, 16'(-256));
        beat(16'd0, 16'd0, 16'd1000);
        beat(16'd0, 16'd0, 16'(-5000));
        beat(16'd0, 16'd0, 16'd32767);
        expect_result("bias", -256, 0, 1'b0);
        idle(1);

        // 4 x 128 = 512 -> (512+128)>>>8 = 2
        vec4(16'd1, 16'd128, 16'd0);
        expect_result("round4", 2, 0, 1'b0);
        idle(1);

        vec4(16'd32767, 16'd32767, 16'd0);
        expect_result("satpos", 32767, 1, 1'b0);
        idle(1);

        vec4(16'd32767, 16'h8000, 16'd0);
        expect_result("satneg", -32768, 1, 1'b0);
        idle(1);

        // Outputs hold until the next result, then sat clears
        beat(16'd256, 16'd128, 16'd0);
        chk("hold.y", $signed(bus.y_out), -32768);
        chk("hold.sat", {31'd0, bus.sat_out}, 1);
        repeat (3) beat(16'd256, 16'd128, 16'd0);
        expect_result("satclr", 512, 0, 1'b0);
        idle(1);

        // Mixed vector: 0.5 + 2.0 - 0.25 - 1.5 + bias 1.0 = 1.75
        beat(16'd256, 16'd128, 16'd256);
        beat(16'd512, 16'd256, 16'd0);
        beat(16'(-256), 16'd64, 16'd0);
        beat(16'd768, 16'(-128), 16'd0);
        expect_result("dense", 448, 0, 1'b0);
        idle(1);

        beat(16'd256, 16'd128, 16'd256);
        idle(2);
        chk("bubble.rdy", {31'd0, bus.in_ready}, 1);
        beat(16'd512, 16'd256, 16'd0);
        beat(16'(-256), 16'd64, 16'd0);
        idle(1);
        beat(16'd768, 16'(-128), 16'd0);
        expect_result("bubble", 448, 0, 1'b0);
        idle(1);

        // Beats held during DRAIN/OUT must be ignored
        vec4(16'd256, 16'd128, 16'd0);
        expect_result("ignore", 512, 0, 1'b1);
        idle(1);

        // Back-to-back: second vector's first beat at edge k+3
        vec4(16'd256, 16'd128, 16'd0);
        expect_result("b2b_a", 512, 0, 1'b0);
        beat(16'(-512), 16'd256, 16'd0);
        chk("b2b.pulse_end", {31'd0, bus.valid_out}, 0);
        repeat (3) beat(16'(-512), 16'd256, 16'd0);
        expect_result("b2b_b", -2048, 0, 1'b0);
        idle(1);

        // Reset mid-vector
        beat(16'd256, 16'd128, 16'd0);
        beat(16'd256, 16'd128, 16'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rstmid.y",   $signed(bus.y_out), 0);
        chk("rstmid.sat", {31'd0, bus.sat_out}, 0);
        chk("rstmid.rdy", {31'd0, bus.in_ready}, 1);
        chk("rstmid.vo0", {31'd0, bus.valid_out}, 0);
        idle(3);
        chk("rstmid.vo3", {31'd0, bus.valid_out}, 0);
        vec4(16'd256, 16'd128, 16'd0);
        expect_result("postrst", 512, 0, 1'b0);
        idle(1);

        // N=1: (128+128)>>>8 = 1
        bus1.valid_in = 1'b1;
        bus1.x_in     = 16'd1;
        bus1.w_in     = 16'd128;
        bus1.bias_in  = 16'd0;
        @(posedge clk);
        #1;
        bus1.valid_in = 1'b0;
        chk("n1.rdy_k", {31'd0, bus1.in_ready}, 0);
        @(posedge clk);
        #1;
        chk("n1.vo_k1", {31'd0, bus1.valid_out}, 0);
        @(posedge clk);
        #1;
        chk("n1.vo",  {31'd0, bus1.valid_out}, 1);
        chk("n1.y",   $signed(bus1.y_out), 1);
        chk("n1.sat", {31'd0, bus1.sat_out}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
